ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand logic that directly feeds the ALU.
- Registers decoded instruction fields, and resolves the 4-bit ALU control code from funct and alu_op.
- Applies EX/MEM and MEM/WB forwarding, then presents final operands a and b, the control code, and the store data to the ALU.
- Provides stall (hold) and flush (bubble insert) for the hazard unit.

---
 rtl/ex_operand_stage.sv | 186 ++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with ALU control decode and operand forwarding
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic [2:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_imm_zext,
  input  logic              id_lui,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_ADDU = 4'b0011;
  localparam logic [3:0] C_SUBU = 4'b0100;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_XOR  = 4'b1101;

  logic [3:0]        dec_ctrl;
  logic              dec_illegal;
  logic              dec_shift_imm;
  logic [DATA_W-1:0] dec_ext;

  logic [DATA_W-1:0] rs_data_q, rt_data_q, ext_q;
  logic [4:0]        shamt_q;
  logic [REG_W-1:0]  rs_q, rt_q;
  logic              alu_src_q, lui_q, shift_imm_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    dec_ctrl      = C_ADD;
    dec_illegal   = 1'b0;
    dec_shift_imm = 1'b0;
    case (id_alu_op)
      3'b000: dec_ctrl = C_ADD;
      3'b001: dec_ctrl = C_SUB;
      3'b011: dec_ctrl = C_AND;
      3'b100: dec_ctrl = C_OR;
      3'b101: dec_ctrl = C_XOR;
      3'b110: dec_ctrl = C_SLT;
      3'b111: dec_ctrl = C_SLTU;
      default: begin
        case (id_funct)
          6'b100000: dec_ctrl = C_ADD;
          6'b100001: dec_ctrl = C_ADDU;
          6'b100010: dec_ctrl = C_SUB;
          6'b100011: dec_ctrl = C_SUBU;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100110: dec_ctrl = C_XOR;
          6'b100111: dec_ctrl = C_NOR;
          6'b101010: dec_ctrl = C_SLT;
          6'b101011: dec_ctrl = C_SLTU;
          6'b000000: begin dec_ctrl = C_SLL; dec_shift_imm = 1'b1; end
          6'b000010: begin dec_ctrl = C_SRL; dec_shift_imm = 1'b1; end
          6'b000011: begin dec_ctrl = C_SRA; dec_shift_imm = 1'b1; end
          6'b000100: dec_ctrl = C_SLL;
          6'b000110: dec_ctrl = C_SRL;
          6'b000111: dec_ctrl = C_SRA;
          default:   dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    dec_ext = {{(DATA_W-16){id_imm[15]}}, id_imm};
    if (id_lui)
      dec_ext = {{(DATA_W-32){1'b0}}, id_imm, 16'h0000};
    else if (id_imm_zext)
      dec_ext = {{(DATA_W-16){1'b0}}, id_imm};
  end

  // A bubble is the reset image: zero fields and rs = rt = 0 so nothing forwards.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rs_data_q     <= '0;
      rt_data_q     <= '0;
      ext_q         <= '0;
      shamt_q       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      alu_src_q     <= 1'b0;
      lui_q         <= 1'b0;
      shift_imm_q   <= 1'b0;
      alu_control   <= C_ADD;
      ex_write_reg  <= '0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall) begin
      rs_data_q     <= id_rs_data;
      rt_data_q     <= id_rt_data;
      ext_q         <= dec_ext;
      shamt_q       <= id_shamt;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      alu_src_q     <= id_alu_src;
      lui_q         <= id_lui;
      shift_imm_q   <= dec_shift_imm;
      alu_control   <= dec_ctrl;
      ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
      ex_valid      <= id_valid;
      ex_reg_write  <= id_reg_write & ~dec_illegal;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_illegal    <= id_valid & dec_illegal;
    end
  end

  // EX/MEM is the younger producer, so it is checked first.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_reg_write && exmem_rd == rs_q && rs_q != '0)
      fwd_rs = exmem_result;
    else if (memwb_reg_write && memwb_rd == rs_q && rs_q != '0)
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_reg_write && exmem_rd == rt_q && rt_q != '0)
      fwd_rt = exmem_result;
    else if (memwb_reg_write && memwb_rd == rt_q && rt_q != '0)
      fwd_rt = memwb_result;
  end

  always_comb begin
    if (shift_imm_q)
      alu_a = {{(DATA_W-5){1'b0}}, shamt_q};
    else if (lui_q)
      alu_a = '0;
    else
      alu_a = fwd_rs;
  end

  assign alu_b         = alu_src_q ? ext_q : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_imm_zext, id_lui, id_reg_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_write_reg;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_imm_zext(id_imm_zext), .id_lui(id_lui), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = 6'b100000; id_alu_op = 3'b000;
    id_alu_src = 1'b0; id_imm_zext = 1'b0; id_lui = 1'b0; id_reg_dst = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    clear_id();
    id_valid = 1'b1; id_alu_op = 3'b010; id_funct = funct; id_reg_dst = 1'b1;
    id_reg_write = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rtype(6'b100010, 5'd1, 5'd2, 5'd3, 32'h1111, 32'h2222);
    id_mem_read = 1'b1; id_mem_write = 1'b1; id_mem_to_reg = 1'b1; id_alu_src = 1'b1; id_imm = 16'h7777;
    exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hDEAD;
    repeat (2) step();
    chk("rst_a", alu_a, 32'h0);
    chk("rst_b", alu_b, 32'h0);
    chk("rst_ctrl", {28'h0, alu_control}, 32'h2);
    chk("rst_store", ex_store_data, 32'h0);
    chk("rst_flags", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal}, 32'h0);
    chk("rst_wreg", {27'h0, ex_write_reg}, 32'h0);

    rst_n = 1'b1;
    rtype(6'b100010, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3);
    step();
    chk("sub_a", alu_a, 32'd7);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_ctrl", {28'h0, alu_control}, 32'h6);
    chk("sub_wreg", {27'h0, ex_write_reg}, 32'd3);
    chk("sub_vld_rw", {30'h0, ex_valid, ex_reg_write}, 32'h3);

    rtype(6'b000000, 5'd4, 5'd2, 5'd8, 32'h99, 32'd1);
    id_shamt = 5'd4;
    step();
    chk("sll_a", alu_a, 32'd4);
    chk("sll_b", alu_b, 32'd1);
    chk("sll_ctrl", {28'h0, alu_control}, 32'h8);

    rtype(6'b000111, 5'd4, 5'd2, 5'd8, 32'h25, 32'h8000_0000);
    id_shamt = 5'd9;
    step();
    chk("srav_a", alu_a, 32'h25);
    chk("srav_ctrl", {28'h0, alu_control}, 32'hB);

    clear_id();
    id_valid = 1'b1; id_alu_op = 3'b000; id_alu_src = 1'b1; id_imm = 16'hFFFF;
    id_rt = 5'd9; id_rd = 5'd12; id_reg_write = 1'b1; id_rs = 5'd1; id_rs_data = 32'h10;
    step();
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_ctrl", {28'h0, alu_control}, 32'h2);
    chk("addi_wreg", {27'h0, ex_write_reg}, 32'd9);

    clear_id();
    id_valid = 1'b1; id_alu_op = 3'b100; id_alu_src = 1'b1; id_imm_zext = 1'b1; id_imm = 16'h8000;
    step();
    chk("ori_b", alu_b, 32'h0000_8000);
    chk("ori_ctrl", {28'h0, alu_control}, 32'h1);

    clear_id();
    id_valid = 1'b1; id_alu_op = 3'b100; id_alu_src = 1'b1; id_lui = 1'b1; id_imm = 16'h1234;
    id_rs = 5'd3; id_rs_data = 32'h55;
    step();
    chk("lui_a", alu_a, 32'h0);
    chk("lui_b", alu_b, 32'h1234_0000);
    chk("lui_ctrl", {28'h0, alu_control}, 32'h1);

    clear_id();
    id_valid = 1'b1; id_alu_op = 3'b000; id_alu_src = 1'b1; id_imm = 16'h0004;
    id_mem_write = 1'b1; id_rs = 5'd2; id_rt = 5'd6; id_rs_data = 32'h100; id_rt_data = 32'hCAFE;
    step();
    chk("sw_b", alu_b, 32'h4);
    chk("sw_store", ex_store_data, 32'hCAFE);
    chk("sw_memw", {31'h0, ex_mem_write}, 32'h1);

    rtype(6'b100000, 5'd5, 5'd5, 5'd10, 32'd1, 32'd2);
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBB;
    step();
    chk("fwd_ex_a", alu_a, 32'hAA);
    chk("fwd_ex_b", alu_b, 32'hAA);
    chk("fwd_ex_st", ex_store_data, 32'hAA);
    exmem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_a", alu_a, 32'hBB);
    chk("fwd_wb_b", alu_b, 32'hBB);
    memwb_reg_write = 1'b0;
    #1;
    chk("fwd_none_a", alu_a, 32'd1);
    chk("fwd_none_b", alu_b, 32'd2);

    rtype(6'b100000, 5'd5, 5'd6, 5'd10, 32'd1, 32'd2);
    exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hEE;
    step();
    chk("fwd_rt_only_a", alu_a, 32'd1);
    chk("fwd_rt_only_b", alu_b, 32'hEE);

    rtype(6'b100000, 5'd0, 5'd0, 5'd10, 32'h11, 32'h22);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    step();
    chk("r0_a", alu_a, 32'h11);
    chk("r0_b", alu_b, 32'h22);

    rtype(6'b100000, 5'd1, 5'd2, 5'd7, 32'h100, 32'h200);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rtype(6'b100010, 5'd3, 5'd4, 5'd9 + 5'(i), 32'h300 + 32'(i), 32'h400);
      id_alu_src = 1'b1; id_imm = 16'h0042;
      step();
      chk("stall_a", alu_a, 32'h100);
      chk("stall_b", alu_b, 32'h200);
      chk("stall_ctrl", {28'h0, alu_control}, 32'h2);
      chk("stall_wreg", {27'h0, ex_write_reg}, 32'd7);
    end

    flush = 1'b1;
    step();
    chk("flush_vld_rw", {30'h0, ex_valid, ex_reg_write}, 32'h0);
    chk("flush_ctrl", {28'h0, alu_control}, 32'h2);
    chk("flush_a", alu_a, 32'h0);
    chk("flush_b", alu_b, 32'h0);

    stall = 1'b0; flush = 1'b0;
    rtype(6'b111111, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6);
    step();
    chk("ill_flag", {31'h0, ex_illegal}, 32'h1);
    chk("ill_rw", {31'h0, ex_reg_write}, 32'h0);
    chk("ill_ctrl", {28'h0, alu_control}, 32'h2);

    flush = 1'b1;
    step();
    chk("ill_cleared", {31'h0, ex_illegal}, 32'h0);
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
